tx_mrd_arb: RTL and testbench

Arbitrates between the primary DMA read-chunk requester and the retry monitor's re-issue requests. The winning request becomes a single PCIe Memory Read TLP on the 64-bit TRN transmit interface of the Virtex-5 endpoint. It sits directly downstream of the retry monitor: it consumes that block's `retry_*` request/ack handshake. It also provides the `read_chunk_ack` that both the DMA engine and the retry monitor use to register outstanding reads.

---
 rtl/tx_mrd_arb.sv | 204 ++++++++++++++++++++
 tb/tb_tx_mrd_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_mrd_arb.sv
// Purpose : arbitrates primary DMA read chunks against retry re-issues and emits one 2-beat PCIe MRd TLP per grant on TRN TX.
// Latency : request sampled in IDLE at edge N -> ack in cycle N+1, BEAT0 from N+2, BEAT1 one cycle after BEAT0 accepted.
// Backpres: trn_tdst_rdy_n high holds every TRN output; trn_tdst_dsc_n low aborts the TLP and pulses tlp_dropped.
//
// Ports:
//   trn_clk, reset_n                     clock, async active-low reset
//   cfg_completer_id                     requester ID placed in header DW1
//   huge_page_addr_read_from/read_chunk/tlp_tag/qwords_to_rd -> read_chunk_ack           primary requester
//   retry_huge_page_addr_read_from/retry_read_chunk/retry_tlp_tag/retry_dwords_to_rd -> retry_read_chunk_ack
//   trn_td/trn_trem_n/trn_tsof_n/trn_teof_n/trn_tsrc_rdy_n, trn_tdst_rdy_n/trn_tdst_dsc_n  TRN transmit
//   tlp_dropped                          one-cycle pulse when a TLP is discontinued
module tx_mrd_arb (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic [15:0] cfg_completer_id,
    input  logic [63:0] huge_page_addr_read_from,
    input  logic        read_chunk,
    input  logic [3:0]  tlp_tag,
    input  logic [8:0]  qwords_to_rd,
    output logic        read_chunk_ack,
    input  logic [63:0] retry_huge_page_addr_read_from,
    input  logic        retry_read_chunk,
    input  logic [3:0]  retry_tlp_tag,
    input  logic [9:0]  retry_dwords_to_rd,
    output logic        retry_read_chunk_ack,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n,
    input  logic        trn_tdst_dsc_n,
    output logic        tlp_dropped
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_BEAT0 = 2'd2,
        S_BEAT1 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  retry_streak_q, retry_streak_d;
    logic [63:0] addr_q, addr_d;
    logic [3:0]  tag_q, tag_d;
    logic [9:0]  dw_len_q, dw_len_d;

    logic        read_chunk_ack_q, read_chunk_ack_d;
    logic        retry_ack_q, retry_ack_d;
    logic        tlp_dropped_q, tlp_dropped_d;
    logic [63:0] td_q, td_d;
    logic [7:0]  trem_n_q, trem_n_d;
    logic        tsof_n_q, tsof_n_d;
    logic        teof_n_q, teof_n_d;
    logic        tsrc_rdy_n_q, tsrc_rdy_n_d;

    // Header fields derived from the latched request.
    logic        is_4dw;
    logic [31:0] hdr_dw0;
    logic [31:0] hdr_dw1;
    logic [3:0]  last_be;
    logic [31:0] addr_lo;
    logic [63:0] beat1_dat;
    logic        retry_wins;

    assign is_4dw  = (addr_q[63:32] != 32'h0);
    // Host addresses are DW aligned; the two low bits never reach the header.
    assign addr_lo = addr_q[31:0] & 32'hFFFF_FFFC;
    // A single-DW read must carry lastBE = 0; a length of 0 means 1024 DW.
    assign last_be = (dw_len_q == 10'd1) ? 4'h0 : 4'hF;

    // DW0: R, fmt, type, R, TC, R, TD, EP, attr, R, length
    assign hdr_dw0 = {1'b0, (is_4dw ? 2'b01 : 2'b00), 5'b00000,
                      1'b0, 3'b000, 4'b0000,
                      1'b0, 1'b0, 2'b00, 2'b00, dw_len_q};
    assign hdr_dw1 = {cfg_completer_id, 4'b0000, tag_q, last_be, 4'hF};

    assign beat1_dat = is_4dw ? {addr_q[63:32], addr_lo} : {addr_lo, 32'h0};

    // Retry normally wins; after three back-to-back retry grants a pending
    // primary request gets one turn so DMA reads cannot be starved.
    assign retry_wins = retry_read_chunk && !((retry_streak_q == 2'd3) && read_chunk);

    always_comb begin
        state_d          = state_q;
        retry_streak_d   = retry_streak_q;
        addr_d           = addr_q;
        tag_d            = tag_q;
        dw_len_d         = dw_len_q;
        read_chunk_ack_d = 1'b0;
        retry_ack_d      = 1'b0;
        tlp_dropped_d    = 1'b0;
        td_d             = td_q;
        trem_n_d         = trem_n_q;
        tsof_n_d         = tsof_n_q;
        teof_n_d         = teof_n_q;
        tsrc_rdy_n_d     = tsrc_rdy_n_q;

        case (state_q)
            S_IDLE: begin
                if (retry_wins) begin
                    addr_d         = retry_huge_page_addr_read_from;
                    tag_d          = retry_tlp_tag;
                    dw_len_d       = retry_dwords_to_rd;
                    retry_streak_d = (retry_streak_q == 2'd3) ? 2'd3 : retry_streak_q + 2'd1;
                    retry_ack_d    = 1'b1;
                    state_d        = S_ACK;
                end else if (read_chunk) begin
                    addr_d           = huge_page_addr_read_from;
                    tag_d            = tlp_tag;
                    dw_len_d         = {qwords_to_rd, 1'b0};
                    retry_streak_d   = 2'd0;
                    read_chunk_ack_d = 1'b1;
                    state_d          = S_ACK;
                end
            end

            // The ack flop is already high in this state; load the header beat.
            S_ACK: begin
                td_d         = {hdr_dw0, hdr_dw1};
                trem_n_d     = 8'h00;
                tsof_n_d     = 1'b0;
                teof_n_d     = 1'b1;
                tsrc_rdy_n_d = 1'b0;
                state_d      = S_BEAT0;
            end

            S_BEAT0: begin
                if (!trn_tdst_dsc_n) begin
                    tlp_dropped_d = 1'b1;
                    td_d          = 64'h0;
                    trem_n_d      = 8'hFF;
                    tsof_n_d      = 1'b1;
                    teof_n_d      = 1'b1;
                    tsrc_rdy_n_d  = 1'b1;
                    state_d       = S_IDLE;
                end else if (!trn_tdst_rdy_n) begin
                    td_d     = beat1_dat;
                    trem_n_d = is_4dw ? 8'h00 : 8'h0F;
                    tsof_n_d = 1'b1;
                    teof_n_d = 1'b0;
                    state_d  = S_BEAT1;
                end
            end

            S_BEAT1: begin
                if (!trn_tdst_dsc_n || !trn_tdst_rdy_n) begin
                    tlp_dropped_d = !trn_tdst_dsc_n;
                    td_d          = 64'h0;
                    trem_n_d      = 8'hFF;
                    tsof_n_d      = 1'b1;
                    teof_n_d      = 1'b1;
                    tsrc_rdy_n_d  = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            retry_streak_q   <= 2'd0;
            addr_q           <= 64'h0;
            tag_q            <= 4'h0;
            dw_len_q         <= 10'h0;
            read_chunk_ack_q <= 1'b0;
            retry_ack_q      <= 1'b0;
            tlp_dropped_q    <= 1'b0;
            td_q             <= 64'h0;
            trem_n_q         <= 8'hFF;
            tsof_n_q         <= 1'b1;
            teof_n_q         <= 1'b1;
            tsrc_rdy_n_q     <= 1'b1;
        end else begin
            state_q          <= state_d;
            retry_streak_q   <= retry_streak_d;
            addr_q           <= addr_d;
            tag_q            <= tag_d;
            dw_len_q         <= dw_len_d;
            read_chunk_ack_q <= read_chunk_ack_d;
            retry_ack_q      <= retry_ack_d;
            tlp_dropped_q    <= tlp_dropped_d;
            td_q             <= td_d;
            trem_n_q         <= trem_n_d;
            tsof_n_q         <= tsof_n_d;
            teof_n_q         <= teof_n_d;
            tsrc_rdy_n_q     <= tsrc_rdy_n_d;
        end
    end

    assign read_chunk_ack       = read_chunk_ack_q;
    assign retry_read_chunk_ack = retry_ack_q;
    assign tlp_dropped          = tlp_dropped_q;
    assign trn_td               = td_q;
    assign trn_trem_n           = trem_n_q;
    assign trn_tsof_n           = tsof_n_q;
    assign trn_teof_n           = teof_n_q;
    assign trn_tsrc_rdy_n       = tsrc_rdy_n_q;

endmodule

// File: tb/tb_tx_mrd_arb.sv
// Purpose : directed self-checking bench for tx_mrd_arb.
// Latency : outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpres: bench drives trn_tdst_rdy_n / trn_tdst_dsc_n directly to exercise stall and abort.
module tb_tx_mrd_arb;

    logic        trn_clk = 1'b0;
    logic        reset_n;
    logic [15:0] cfg_completer_id;
    logic [63:0] huge_page_addr_read_from;
    logic        read_chunk;
    logic [3:0]  tlp_tag;
    logic [8:0]  qwords_to_rd;
    logic        read_chunk_ack;
    logic [63:0] retry_huge_page_addr_read_from;
    logic        retry_read_chunk;
    logic [3:0]  retry_tlp_tag;
    logic [9:0]  retry_dwords_to_rd;
    logic        retry_read_chunk_ack;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic        trn_tdst_dsc_n;
    logic        tlp_dropped;

    int tests_run    = 0;
    int tests_failed = 0;
    int sof_acc      = 0;
    int eof_acc      = 0;

    localparam logic [15:0] CID = 16'h0108;

    tx_mrd_arb dut (
        .trn_clk                        (trn_clk),
        .reset_n                        (reset_n),
        .cfg_completer_id               (cfg_completer_id),
        .huge_page_addr_read_from       (huge_page_addr_read_from),
        .read_chunk                     (read_chunk),
        .tlp_tag                        (tlp_tag),
        .qwords_to_rd                   (qwords_to_rd),
        .read_chunk_ack                 (read_chunk_ack),
        .retry_huge_page_addr_read_from (retry_huge_page_addr_read_from),
        .retry_read_chunk               (retry_read_chunk),
        .retry_tlp_tag                  (retry_tlp_tag),
        .retry_dwords_to_rd             (retry_dwords_to_rd),
        .retry_read_chunk_ack           (retry_read_chunk_ack),
        .trn_td                         (trn_td),
        .trn_trem_n                     (trn_trem_n),
        .trn_tsof_n                     (trn_tsof_n),
        .trn_teof_n                     (trn_teof_n),
        .trn_tsrc_rdy_n                 (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n                 (trn_tdst_rdy_n),
        .trn_tdst_dsc_n                 (trn_tdst_dsc_n),
        .tlp_dropped                    (tlp_dropped)
    );

    always #5 trn_clk = ~trn_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; counts sof/eof beats the sink accepts at this edge.
    task automatic tick();
        if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n && trn_tdst_dsc_n) begin
            if (!trn_tsof_n) sof_acc++;
            if (!trn_teof_n) eof_acc++;
        end
        @(posedge trn_clk);
        #1;
    endtask

    // Bounded wait for an ack: 1 = primary, 2 = retry, 3 = both, 0 = timeout.
    task automatic wait_ack(output int who);
        who = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (read_chunk_ack || retry_read_chunk_ack) break;
        end
        if (read_chunk_ack && retry_read_chunk_ack) who = 3;
        else if (read_chunk_ack)                     who = 1;
        else if (retry_read_chunk_ack)               who = 2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   {62'h0, read_chunk_ack, retry_read_chunk_ack}, 64'h0);
        chk({tag, "_drop"},  {63'h0, tlp_dropped}, 64'h0);
        chk({tag, "_ctl"},   {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h7);
        chk({tag, "_td"},    trn_td, 64'h0);
        chk({tag, "_trem"},  {56'h0, trn_trem_n}, 64'hFF);
    endtask

    initial begin
        int who;
        int order [4];

        reset_n                        = 1'b0;
        cfg_completer_id               = CID;
        huge_page_addr_read_from       = 64'h0;
        read_chunk                     = 1'b0;
        tlp_tag                        = 4'h0;
        qwords_to_rd                   = 9'h0;
        retry_huge_page_addr_read_from = 64'h0;
        retry_read_chunk               = 1'b0;
        retry_tlp_tag                  = 4'h0;
        retry_dwords_to_rd             = 10'h0;
        trn_tdst_rdy_n                 = 1'b0;
        trn_tdst_dsc_n                 = 1'b1;

        repeat (2) @(posedge trn_clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Primary 3DW, tag 3, 64 QW -> 128 DW
        huge_page_addr_read_from = 64'h0000_0000_1234_5000;
        tlp_tag                  = 4'd3;
        qwords_to_rd             = 9'd64;
        read_chunk               = 1'b1;
        tick();
        chk("p3dw_ack", {62'h0, read_chunk_ack, retry_read_chunk_ack}, 64'h2);
        chk("p3dw_ack_src_rdy", {63'h0, trn_tsrc_rdy_n}, 64'h1);
        read_chunk = 1'b0;
        tick();
        chk("p3dw_ack_single", {63'h0, read_chunk_ack}, 64'h0);
        chk("p3dw_b0_td", trn_td, {32'h0000_0080, CID, 16'h03FF});
        chk("p3dw_b0_ctl", {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h1);
        tick();
        chk("p3dw_b1_td", trn_td, {32'h1234_5000, 32'h0});
        chk("p3dw_b1_trem", {56'h0, trn_trem_n}, 64'h0F);
        chk("p3dw_b1_ctl", {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h2);
        tick();
        chk("p3dw_idle_ctl", {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h7);

        // Retry 4DW, length 1, tag 9
        retry_huge_page_addr_read_from = 64'h0000_0001_0000_0040;
        retry_dwords_to_rd             = 10'd1;
        retry_tlp_tag                  = 4'd9;
        retry_read_chunk               = 1'b1;
        tick();
        chk("r4dw_ack", {62'h0, read_chunk_ack, retry_read_chunk_ack}, 64'h1);
        retry_read_chunk = 1'b0;
        tick();
        chk("r4dw_b0_td", trn_td, {32'h2000_0001, CID, 16'h090F});
        tick();
        chk("r4dw_b1_td", trn_td, 64'h0000_0001_0000_0040);
        chk("r4dw_b1_trem", {56'h0, trn_trem_n}, 64'h00);
        tick();

        // Simultaneous requests: retry first, then primary
        huge_page_addr_read_from       = 64'h0000_0000_0000_8000;
        tlp_tag                        = 4'd1;
        qwords_to_rd                   = 9'd4;
        retry_huge_page_addr_read_from = 64'h0000_0000_0000_9000;
        retry_tlp_tag                  = 4'd7;
        retry_dwords_to_rd             = 10'd8;
        read_chunk                     = 1'b1;
        retry_read_chunk               = 1'b1;
        wait_ack(who);
        chk("simul_first", who, 2);
        retry_read_chunk = 1'b0;
        wait_ack(who);
        chk("simul_second", who, 1);
        read_chunk = 1'b0;
        repeat (3) tick();

        // Starvation guard: R, R, R, P
        read_chunk       = 1'b1;
        retry_read_chunk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(who);
            order[k] = who;
            if (who == 1) read_chunk = 1'b0;
        end
        retry_read_chunk = 1'b0;
        chk("streak_g0", order[0], 2);
        chk("streak_g1", order[1], 2);
        chk("streak_g2", order[2], 2);
        chk("streak_g3", order[3], 1);
        repeat (3) tick();
        chk("streak_idle", {63'h0, trn_tsrc_rdy_n}, 64'h1);

        // Backpressure: 5 stalled cycles in BEAT0, 3 in BEAT1
        sof_acc = 0;
        eof_acc = 0;
        trn_tdst_rdy_n           = 1'b1;
        huge_page_addr_read_from = 64'h0000_0000_0000_1000;
        tlp_tag                  = 4'd5;
        qwords_to_rd             = 9'd1;
        read_chunk               = 1'b1;
        wait_ack(who);
        chk("bp_ack", who, 1);
        read_chunk = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("bp_b0_td", trn_td, {32'h0000_0002, CID, 16'h05FF});
            chk("bp_b0_ctl", {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h1);
            if (i < 5) tick();
        end
        trn_tdst_rdy_n = 1'b0;
        tick();
        trn_tdst_rdy_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_b1_td", trn_td, {32'h0000_1000, 32'h0});
            chk("bp_b1_trem", {56'h0, trn_trem_n}, 64'h0F);
            chk("bp_b1_ctl", {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h2);
            if (i < 3) tick();
        end
        trn_tdst_rdy_n = 1'b0;
        tick();
        chk("bp_idle_ctl", {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h7);
        chk("bp_sof_count", sof_acc, 1);
        chk("bp_eof_count", eof_acc, 1);

        // Discontinue in BEAT1
        retry_huge_page_addr_read_from = 64'h0000_0000_0000_2000;
        retry_tlp_tag                  = 4'd2;
        retry_dwords_to_rd             = 10'd16;
        retry_read_chunk               = 1'b1;
        wait_ack(who);
        chk("dsc_ack", who, 2);
        retry_read_chunk = 1'b0;
        tick();
        tick();
        chk("dsc_b1_ctl", {61'h0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'h2);
        chk("dsc_pre_drop", {63'h0, tlp_dropped}, 64'h0);
        trn_tdst_dsc_n = 1'b0;
        trn_tdst_rdy_n = 1'b1;
        tick();
        chk("dsc_src_rdy", {63'h0, trn_tsrc_rdy_n}, 64'h1);
        chk("dsc_drop", {63'h0, tlp_dropped}, 64'h1);
        trn_tdst_dsc_n = 1'b1;
        trn_tdst_rdy_n = 1'b0;
        tick();
        chk("dsc_drop_once", {63'h0, tlp_dropped}, 64'h0);
        huge_page_addr_read_from = 64'h0000_0000_0000_4000;
        tlp_tag                  = 4'd6;
        qwords_to_rd             = 9'd2;
        read_chunk               = 1'b1;
        wait_ack(who);
        chk("dsc_next_ack", who, 1);
        read_chunk = 1'b0;
        tick();
        chk("dsc_next_b0_td", trn_td, {32'h0000_0004, CID, 16'h06FF});
        tick();
        tick();

        // Reset during BEAT0
        huge_page_addr_read_from = 64'h0000_0000_0000_5000;
        tlp_tag                  = 4'hA;
        qwords_to_rd             = 9'd8;
        read_chunk               = 1'b1;
        wait_ack(who);
        read_chunk = 1'b0;
        tick();
        chk("rst_pre_src_rdy", {63'h0, trn_tsrc_rdy_n}, 64'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge trn_clk);
        #1;
        reset_n = 1'b1;

        // Retry length 1024 (encoded 0)
        retry_huge_page_addr_read_from = 64'h0000_0000_0000_3000;
        retry_tlp_tag                  = 4'd4;
        retry_dwords_to_rd             = 10'd0;
        retry_read_chunk               = 1'b1;
        wait_ack(who);
        chk("len1024_ack", who, 2);
        retry_read_chunk = 1'b0;
        tick();
        chk("len1024_b0_td", trn_td, {32'h0000_0000, CID, 16'h04FF});
        tick();
        chk("len1024_b1_td", trn_td, {32'h0000_3000, 32'h0});
        chk("len1024_b1_trem", {56'h0, trn_trem_n}, 64'h0F);
        tick();
        chk("len1024_idle", {63'h0, trn_tsrc_rdy_n}, 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
